// File: rtl/hockey_input_cond.sv
// Input conditioner for the hockey core: synchronizes and debounces both player buttons,
// emits one-cycle press pulses and captures clamped DIR/Y at each accepted press.
module hockey_input_cond #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned Y_MAX    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       BTNA,
  input  logic       BTNB,
  input  logic [1:0] DIRA,
  input  logic [1:0] DIRB,
  input  logic [2:0] YA,
  input  logic [2:0] YB,
  output logic       BTNA_P,
  output logic       BTNB_P,
  output logic [1:0] DIRA_Q,
  output logic [1:0] DIRB_Q,
  output logic [2:0] YA_Q,
  output logic [2:0] YB_Q
);

  localparam int unsigned CntW = $clog2(DEBOUNCE) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE - 1);

  // Channel index 0 is player A, 1 is player B.
  logic [1:0]            w_btn_raw;
  logic [1:0][1:0]       w_dir_raw;
  logic [1:0][2:0]       w_y_raw;

  logic [1:0]            r_btn_s1, r_btn_s2;
  logic [1:0][1:0]       r_dir_s1, r_dir_s2;
  logic [1:0][2:0]       r_y_s1, r_y_s2;

  logic [1:0]            r_stable;
  logic [1:0][CntW-1:0]  r_cnt;
  logic [1:0][CntW-1:0]  w_cnt_d;
  logic [1:0]            w_accept;
  logic [1:0]            w_press;
  logic [1:0][2:0]       w_y_clamp;

  logic [1:0]            r_pulse;
  logic [1:0][1:0]       r_dir_q;
  logic [1:0][2:0]       r_y_q;

  assign w_btn_raw = {BTNB, BTNA};
  assign w_dir_raw = {DIRB, DIRA};
  assign w_y_raw   = {YB, YA};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_dir_s1 <= '0;
      r_dir_s2 <= '0;
      r_y_s1   <= '0;
      r_y_s2   <= '0;
    end else begin
      r_btn_s1 <= w_btn_raw;
      r_btn_s2 <= r_btn_s1;
      r_dir_s1 <= w_dir_raw;
      r_dir_s2 <= r_dir_s1;
      r_y_s1   <= w_y_raw;
      r_y_s2   <= r_y_s1;
    end
  end

  // A level change is accepted on the DEBOUNCE-th consecutive differing sample; any sample
  // matching the accepted level restarts the count.
  always_comb begin
    w_accept  = '0;
    w_press   = '0;
    w_cnt_d   = '0;
    w_y_clamp = '0;
    for (int c = 0; c < 2; c++) begin
      w_accept[c] = (r_btn_s2[c] != r_stable[c]) && (r_cnt[c] == CntLast);
      w_press[c]  = w_accept[c] && r_btn_s2[c];
      if ((r_btn_s2[c] == r_stable[c]) || w_accept[c]) begin
        w_cnt_d[c] = '0;
      end else begin
        w_cnt_d[c] = r_cnt[c] + CntW'(1);
      end
      w_y_clamp[c] = ({29'd0, r_y_s2[c]} > Y_MAX) ? 3'(Y_MAX) : r_y_s2[c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stable <= '0;
      r_cnt    <= '0;
      r_pulse  <= '0;
      r_dir_q  <= '0;
      r_y_q    <= '0;
    end else begin
      r_stable <= r_stable ^ w_accept;
      r_cnt    <= w_cnt_d;
      r_pulse  <= w_press;
      for (int c = 0; c < 2; c++) begin
        if (w_press[c]) begin
          r_dir_q[c] <= r_dir_s2[c];
          r_y_q[c]   <= w_y_clamp[c];
        end
      end
    end
  end

  assign BTNA_P = r_pulse[0];
  assign BTNB_P = r_pulse[1];
  assign DIRA_Q = r_dir_q[0];
  assign DIRB_Q = r_dir_q[1];
  assign YA_Q   = r_y_q[0];
  assign YB_Q   = r_y_q[1];

endmodule

// File: tb/tb_hockey_input_cond.sv
// Bench for hockey_input_cond: directed scenarios plus random button/DIR/Y traffic, all checked
// against a sample-history reference model of the conditioner.
module tb_hockey_input_cond;

  localparam int DEB  = 4;
  localparam int YMAX = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       BTNA = 1'b0, BTNB = 1'b0;
  logic [1:0] DIRA = '0, DIRB = '0;
  logic [2:0] YA = '0, YB = '0;
  logic       BTNA_P, BTNB_P;
  logic [1:0] DIRA_Q, DIRB_Q;
  logic [2:0] YA_Q, YB_Q;

  int checks = 0;
  int fails  = 0;

  hockey_input_cond #(.DEBOUNCE(DEB), .Y_MAX(YMAX)) dut (
    .clk    (clk),
    .rst    (rst),
    .BTNA   (BTNA),
    .BTNB   (BTNB),
    .DIRA   (DIRA),
    .DIRB   (DIRB),
    .YA     (YA),
    .YB     (YB),
    .BTNA_P (BTNA_P),
    .BTNB_P (BTNB_P),
    .DIRA_Q (DIRA_Q),
    .DIRB_Q (DIRB_Q),
    .YA_Q   (YA_Q),
    .YB_Q   (YB_Q)
  );

  always #5 clk = ~clk;

  // Reference model: remembers raw samples from the last two edges, keeps the history of
  // synchronized button samples since the last accepted change, and accepts a change once the
  // most recent DEB samples all disagree with the accepted level.
  logic         m_d1b[2], m_d2b[2];
  logic [1:0]   m_d1d[2], m_d2d[2];
  logic [2:0]   m_d1y[2], m_d2y[2];
  logic         m_stable[2];
  int           m_since[2];
  logic [255:0] m_hist[2];
  logic         m_p[2];
  logic [1:0]   m_dq[2];
  logic [2:0]   m_yq[2];

  always @(posedge clk) begin : model
    logic       rb[2];
    logic [1:0] rd[2];
    logic [2:0] ry[2];
    logic       accept;
    rb[0] = BTNA; rb[1] = BTNB;
    rd[0] = DIRA; rd[1] = DIRB;
    ry[0] = YA;   ry[1] = YB;
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        m_d1b[c] = 0; m_d2b[c] = 0; m_d1d[c] = 0; m_d2d[c] = 0; m_d1y[c] = 0; m_d2y[c] = 0;
        m_stable[c] = 0; m_since[c] = 0; m_hist[c] = '0;
        m_p[c] = 0; m_dq[c] = 0; m_yq[c] = 0;
      end else begin
        m_hist[c]  = {m_hist[c][254:0], m_d2b[c]};
        m_since[c] = m_since[c] + 1;
        accept = (m_since[c] >= DEB);
        for (int k = 0; k < DEB; k++) if (m_hist[c][k] == m_stable[c]) accept = 0;
        m_p[c] = 0;
        if (accept) begin
          m_stable[c] = ~m_stable[c];
          m_since[c]  = 0;
          if (m_stable[c]) begin
            m_p[c]  = 1;
            m_dq[c] = m_d2d[c];
            m_yq[c] = (int'(m_d2y[c]) > YMAX) ? 3'(YMAX) : m_d2y[c];
          end
        end
        m_d2b[c] = m_d1b[c]; m_d1b[c] = rb[c];
        m_d2d[c] = m_d1d[c]; m_d1d[c] = rd[c];
        m_d2y[c] = m_d1y[c]; m_d1y[c] = ry[c];
      end
    end
  end

  function automatic logic [11:0] dut_vec();
    return {BTNA_P, BTNB_P, DIRA_Q, DIRB_Q, YA_Q, YB_Q};
  endfunction

  function automatic logic [11:0] model_vec();
    return {m_p[0], m_p[1], m_dq[0], m_dq[1], m_yq[0], m_yq[1]};
  endfunction

  // Advance one rising edge and settle at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (dut_vec() !== 12'h000) begin
        fails++;
        $display("FAIL reset_idle cycle %0d: got %h expected 000", i, dut_vec());
      end
    end
  endtask

  task automatic test_press_a();
    DIRA = 2'd1; YA = 3'd2; BTNA = 1'b1;
    for (int e = 0; e < 20; e++) begin
      tick();
      checks++;
      if (BTNA_P !== (e == 5)) begin
        fails++;
        $display("FAIL press_a_pulse edge %0d: got %b expected %b", e, BTNA_P, e == 5);
      end
      checks++;
      if (e >= 5 && (DIRA_Q !== 2'd1 || YA_Q !== 3'd2)) begin
        fails++;
        $display("FAIL press_a_capture edge %0d: got dir %0d y %0d expected 1 2", e, DIRA_Q, YA_Q);
      end
      checks++;
      if (dut_vec() !== model_vec()) begin
        fails++;
        $display("FAIL press_a_model edge %0d: got %h expected %h", e, dut_vec(), model_vec());
      end
      if (e == 8) begin DIRA = 2'd3; YA = 3'd7; end
    end
    BTNA = 1'b0;
    for (int e = 0; e < 12; e++) begin
      tick();
      checks++;
      if (BTNA_P !== 1'b0 || DIRA_Q !== 2'd1 || YA_Q !== 3'd2) begin
        fails++;
        $display("FAIL press_a_release cycle %0d: got p %b dir %0d y %0d expected 0 1 2",
                 e, BTNA_P, DIRA_Q, YA_Q);
      end
    end
  endtask

  task automatic test_bounce();
    logic [16:0] pat;
    pat = 17'b0000000000_1110111;
    DIRB = 2'd3; YB = 3'd5;
    for (int e = 0; e < 17; e++) begin
      BTNB = pat[e];
      tick();
      checks++;
      if (BTNB_P !== 1'b0 || DIRB_Q !== 2'd0 || YB_Q !== 3'd0) begin
        fails++;
        $display("FAIL bounce cycle %0d: got p %b dir %0d y %0d expected 0 0 0",
                 e, BTNB_P, DIRB_Q, YB_Q);
      end
      checks++;
      if (dut_vec() !== model_vec()) begin
        fails++;
        $display("FAIL bounce_model cycle %0d: got %h expected %h", e, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_clamp();
    int pulses;
    pulses = 0;
    YB = 3'd6; DIRB = 2'd2; BTNB = 1'b1;
    for (int e = 0; e < 20; e++) begin
      if (e == 10) BTNB = 1'b0;
      tick();
      if (BTNB_P === 1'b1) pulses++;
      checks++;
      if (dut_vec() !== model_vec()) begin
        fails++;
        $display("FAIL clamp_model cycle %0d: got %h expected %h", e, dut_vec(), model_vec());
      end
    end
    checks++;
    if (pulses != 1 || YB_Q !== 3'd4 || DIRB_Q !== 2'd2) begin
      fails++;
      $display("FAIL clamp: got pulses %0d y %0d dir %0d expected 1 4 2", pulses, YB_Q, DIRB_Q);
    end
  endtask

  task automatic test_simultaneous();
    YA = 3'd1; YB = 3'd3; DIRA = 2'd2; DIRB = 2'd1;
    BTNA = 1'b1; BTNB = 1'b1;
    for (int e = 0; e < 20; e++) begin
      if (e == 10) begin BTNA = 1'b0; BTNB = 1'b0; end
      tick();
      checks++;
      if (BTNA_P !== (e == 5) || BTNB_P !== (e == 5)) begin
        fails++;
        $display("FAIL simul_pulse edge %0d: got %b%b expected %b%b",
                 e, BTNA_P, BTNB_P, e == 5, e == 5);
      end
      checks++;
      if (dut_vec() !== model_vec()) begin
        fails++;
        $display("FAIL simul_model edge %0d: got %h expected %h", e, dut_vec(), model_vec());
      end
    end
    checks++;
    if (YA_Q !== 3'd1 || YB_Q !== 3'd3 || DIRA_Q !== 2'd2 || DIRB_Q !== 2'd1) begin
      fails++;
      $display("FAIL simul_capture: got ya %0d yb %0d da %0d db %0d expected 1 3 2 1",
               YA_Q, YB_Q, DIRA_Q, DIRB_Q);
    end
  endtask

  task automatic test_reset_mid();
    YA = 3'd3; DIRA = 2'd3; BTNA = 1'b1;
    for (int e = 0; e < 16; e++) begin
      rst = (e == 3);
      tick();
      checks++;
      if (e >= 3 && e <= 8 && dut_vec() !== 12'h000) begin
        fails++;
        $display("FAIL reset_mid_clear edge %0d: got %h expected 000", e, dut_vec());
      end
      checks++;
      if (BTNA_P !== (e == 9)) begin
        fails++;
        $display("FAIL reset_mid_pulse edge %0d: got %b expected %b", e, BTNA_P, e == 9);
      end
      checks++;
      if (dut_vec() !== model_vec()) begin
        fails++;
        $display("FAIL reset_mid_model edge %0d: got %h expected %h", e, dut_vec(), model_vec());
      end
    end
    rst = 1'b0;
    BTNA = 1'b0;
    for (int e = 0; e < 10; e++) tick();
  endtask

  task automatic test_random();
    int hold[2];
    hold[0] = 0; hold[1] = 0;
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (hold[c] == 0) begin
          hold[c] = $urandom_range(1, 8);
          if (c == 0) BTNA = 1'($urandom_range(0, 1));
          else        BTNB = 1'($urandom_range(0, 1));
        end
        hold[c]--;
      end
      DIRA = 2'($urandom); DIRB = 2'($urandom);
      YA   = 3'($urandom); YB   = 3'($urandom);
      rst  = ($urandom_range(0, 149) == 0);
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        fails++;
        $display("FAIL random_model cycle %0d: got %h expected %h", i, dut_vec(), model_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_press_a();
    test_bounce();
    test_clamp();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
